fixed_act_lut_prog: RTL and testbench
=====================================

// Module: fixed_act_lut_prog
// PURPOSE
//  Runtime-programmable activation look-up table: the writer-side counterpart of the fixed,
//  file-initialised activation LUTs. A host or config stream writes all 2**DATA_IN_0_PRECISION_0
//  entries in order, then the block serves element-wise lookups on the data_in_0 -> data_out_0
//  stream with one registered pipeline stage. It sits in the activation slot of a dataflow
//  graph, so one netlist can implement ELU, GELU, SiLU or any other unary map.
// PARAMETERS
//  DATA_IN_0_PRECISION_0        8   input word width; LUT depth MEM_SIZE = 2**this (localparam)
//  DATA_IN_0_PRECISION_1        4   input fractional bits (informational only, no effect on RTL)
//  DATA_IN_0_PARALLELISM_DIM_0  1   lanes, dim 0
//  DATA_IN_0_PARALLELISM_DIM_1  1   lanes, dim 1; total lanes P = DIM_0*DIM_1
//  DATA_OUT_0_PRECISION_0       8   LUT entry / output width
//  DATA_OUT_0_PRECISION_1       4   output fractional bits (informational only)
// PORTS
//  clk               in   1      clock; all state changes on its rising edge
//  rst               in   1      synchronous reset, active-high
//  lut_wr_data       in   DATA_OUT_0_PRECISION_0  next table entry, index = internal wr_ptr
//  lut_wr_valid      in   1      lut_wr_data is valid
//  lut_wr_ready      out  1      block accepts a table entry this cycle
//  lut_reload        in   1      one-cycle pulse: start reprogramming the table (ignored outside RUN)
//  lut_loaded        out  1      table is complete and lookups are enabled
//  data_in_0         in   P x DATA_IN_0_PRECISION_0   lookup indices (raw bits = unsigned address)
//  data_in_0_valid   in   1      input beat valid
//  data_in_0_ready   out  1      input beat accepted this cycle
//  data_out_0        out  P x DATA_OUT_0_PRECISION_0  looked-up values
//  data_out_0_valid  out  1      output beat valid
//  data_out_0_ready  in   1      downstream accepts the output beat
// BEHAVIOUR
//  Reset: state=EMPTY, wr_ptr=0, lut_loaded=0, data_out_0_valid=0, data_out_0 all lanes 0.
//   LUT contents are not reset: entries are retained, but unusable until a full load completes.
//  Handshakes: a transfer occurs when valid&&ready at the rising edge. Once valid is raised it is
//   held, with data stable, until the transfer. No ready output depends combinationally on
//   lut_reload or lut_wr_valid.
//  FSM: states EMPTY, LOAD, RUN, DRAIN.
//   EMPTY: lut_wr_ready=1, data_in_0_ready=0. A write transfer stores entry[0], sets wr_ptr=1,
//    and moves to LOAD.
//   LOAD: lut_wr_ready=1, data_in_0_ready=0. Each write transfer stores entry[wr_ptr] and
//    increments wr_ptr. The write at wr_ptr==MEM_SIZE-1 wraps wr_ptr to 0 and moves to RUN;
//    lut_loaded=1 from the next cycle.
//   RUN: lut_wr_ready=0, lut_loaded=1, data_in_0_ready = !data_out_0_valid || data_out_0_ready.
//    An input transfer loads data_out_0[i] <= entry[data_in_0[i]] for every lane and sets
//    data_out_0_valid=1 (latency 1 cycle). An output transfer with no input transfer clears
//    data_out_0_valid. Simultaneous output and input transfers give back-to-back beats at full
//    throughput.
//    lut_reload==1 moves to DRAIN next cycle. An input transfer in that same cycle still completes.
//   DRAIN: data_in_0_ready=0, lut_wr_ready=0, lut_loaded=0. Waits until data_out_0_valid==0, or
//    an output transfer happens this cycle, then moves to LOAD with wr_ptr=0. The old table is
//    never overwritten while a beat is pending.
//  lut_reload in EMPTY, LOAD or DRAIN has no effect.
//  Table write and lookup never overlap: writes happen only in EMPTY/LOAD, reads only in RUN.
//  Width rules: the index is a zero-extended unsigned address, so two's-complement negative inputs
//   map to the upper half of the table. Output is the entry verbatim; no rounding or saturation.
//  Reset mid-load or mid-drain returns to EMPTY with wr_ptr=0; a full reload is required.
// TESTING
//  1 Reset, then write entry[i]=255-i for i=0..255 (W=8) -> lut_loaded rises the cycle after the
//    256th write; lut_wr_ready=0 afterwards.
//  2 Inputs 0x00,0x7F,0x80,0xFF on back-to-back beats with data_out_0_ready=1 -> outputs
//    0xFF,0x80,0x7F,0x00, each 1 cycle after its input, with no bubbles.
//  3 Hold data_out_0_ready=0 for 3 cycles with a beat pending -> data_out_0 stable,
//    data_in_0_ready=0, nothing dropped or duplicated after release.
//  4 Pulse lut_reload in the same cycle as an input transfer of 0x05 -> 0xFA is still output.
//    After drain, 256 writes of entry[i]=i take effect: input 0x05 -> 0x05, and no input is
//    accepted while lut_loaded=0.
//  5 Assert rst after 100 writes, then perform 256 writes -> lut_loaded rises only after the
//    256th write; lookups use the new table.
//  6 P=4 lanes, inputs {0x01,0x02,0x80,0xFF} -> four independent lane outputs in a single beat.

Source files
------------

// File: rtl/fixed_act_lut_prog.sv
// Runtime-programmable activation LUT: a config stream fills every entry in order,
// then each lane of data_in_0 is looked up with one registered output stage.
module fixed_act_lut_prog #(
    parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1       = 4,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int unsigned DATA_OUT_0_PRECISION_0      = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1      = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]           lut_wr_data,
    input  logic                                        lut_wr_valid,
    output logic                                        lut_wr_ready,
    input  logic                                        lut_reload,
    output logic                                        lut_loaded,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
                 [DATA_IN_0_PRECISION_0-1:0]            data_in_0,
    input  logic                                        data_in_0_valid,
    output logic                                        data_in_0_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
                 [DATA_OUT_0_PRECISION_0-1:0]           data_out_0,
    output logic                                        data_out_0_valid,
    input  logic                                        data_out_0_ready
);

    localparam int unsigned IN_W     = DATA_IN_0_PRECISION_0;
    localparam int unsigned OUT_W    = DATA_OUT_0_PRECISION_0;
    localparam int unsigned P        = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int unsigned MEM_SIZE = 2 ** IN_W;

    // Fractional widths are metadata only; reject nonsensical settings at elaboration.
    if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0 ||
        DATA_OUT_0_PRECISION_1 > DATA_OUT_0_PRECISION_0) begin : g_bad_frac
        $error("fractional width exceeds word width");
    end

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e                      state_q, state_d;
    logic [IN_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic                        lut_wr_ready_q, lut_wr_ready_d;
    logic                        lut_loaded_q, lut_loaded_d;
    logic                        dout_valid_q, dout_valid_d;
    logic [P-1:0][OUT_W-1:0]     data_out_q, data_out_d;
    logic [OUT_W-1:0]            mem_q [MEM_SIZE];
    logic                        mem_we;
    logic                        wr_xfer, in_xfer, out_xfer;

    assign wr_xfer         = lut_wr_valid && lut_wr_ready_q;
    assign out_xfer        = dout_valid_q && data_out_0_ready;
    assign data_in_0_ready = (state_q == S_RUN) && (!dout_valid_q || data_out_0_ready);
    assign in_xfer         = data_in_0_valid && data_in_0_ready;

    // Next-state, write pointer and output-stage logic.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        mem_we       = 1'b0;
        dout_valid_d = dout_valid_q;
        data_out_d   = data_out_q;
        unique case (state_q)
            S_EMPTY, S_LOAD: begin
                if (wr_xfer) begin
                    mem_we   = !rst;
                    wr_ptr_d = wr_ptr_q + IN_W'(1);
                    state_d  = (wr_ptr_q == IN_W'(MEM_SIZE - 1)) ? S_RUN : S_LOAD;
                end
            end
            S_RUN: begin
                if (lut_reload) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Hold the old table until the pending beat has left.
                if (!dout_valid_q || out_xfer) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (in_xfer) begin
            dout_valid_d = 1'b1;
            for (int unsigned i = 0; i < P; i++) begin
                data_out_d[i] = mem_q[data_in_0[i]];
            end
        end else if (out_xfer) begin
            dout_valid_d = 1'b0;
        end

        lut_wr_ready_d = (state_d == S_EMPTY) || (state_d == S_LOAD);
        lut_loaded_d   = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_EMPTY;
            wr_ptr_q       <= '0;
            lut_wr_ready_q <= 1'b1;
            lut_loaded_q   <= 1'b0;
            dout_valid_q   <= 1'b0;
            data_out_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            lut_wr_ready_q <= lut_wr_ready_d;
            lut_loaded_q   <= lut_loaded_d;
            dout_valid_q   <= dout_valid_d;
            data_out_q     <= data_out_d;
        end
    end

    // Table storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= lut_wr_data;
    end

    assign lut_wr_ready     = lut_wr_ready_q;
    assign lut_loaded       = lut_loaded_q;
    assign data_out_0       = data_out_q;
    assign data_out_0_valid = dout_valid_q;

endmodule

// File: tb/tb_fixed_act_lut_prog.sv
// Directed bench for fixed_act_lut_prog with four lanes and 8-bit words.
module tb_fixed_act_lut_prog;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      lut_wr_data;
    logic            lut_wr_valid;
    logic            lut_wr_ready;
    logic            lut_reload;
    logic            lut_loaded;
    logic [3:0][7:0] data_in_0;
    logic            data_in_0_valid;
    logic            data_in_0_ready;
    logic [3:0][7:0] data_out_0;
    logic            data_out_0_valid;
    logic            data_out_0_ready;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fixed_act_lut_prog #(
        .DATA_IN_0_PRECISION_0      (8),
        .DATA_IN_0_PRECISION_1      (4),
        .DATA_IN_0_PARALLELISM_DIM_0(4),
        .DATA_IN_0_PARALLELISM_DIM_1(1),
        .DATA_OUT_0_PRECISION_0     (8),
        .DATA_OUT_0_PRECISION_1     (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lut_wr_data     (lut_wr_data),
        .lut_wr_valid    (lut_wr_valid),
        .lut_wr_ready    (lut_wr_ready),
        .lut_reload      (lut_reload),
        .lut_loaded      (lut_loaded),
        .data_in_0       (data_in_0),
        .data_in_0_valid (data_in_0_valid),
        .data_in_0_ready (data_in_0_ready),
        .data_out_0      (data_out_0),
        .data_out_0_valid(data_out_0_valid),
        .data_out_0_ready(data_out_0_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: 255-i, mode 1: i, otherwise i^0xA5
    task automatic load_table(input int mode);
        int waits = 0;
        while (!lut_wr_ready && waits < 10) begin
            tick();
            waits++;
        end
        check("wr_ready_before_load", 32'(lut_wr_ready), 1);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       lut_wr_data = 8'(255 - i);
                1:       lut_wr_data = 8'(i);
                default: lut_wr_data = 8'(i) ^ 8'hA5;
            endcase
            lut_wr_valid = 1'b1;
            if (i == 0 || i == 255) begin
                check("loaded_low_during_load", 32'(lut_loaded), 0);
                check("in_ready_low_during_load", 32'(data_in_0_ready), 0);
            end
            tick();
        end
        lut_wr_valid = 1'b0;
        check("loaded_after_load", 32'(lut_loaded), 1);
        check("wr_ready_after_load", 32'(lut_wr_ready), 0);
    endtask

    task automatic lookup(input string tag, input logic [31:0] din, input logic [31:0] exp);
        data_in_0        = din;
        data_in_0_valid  = 1'b1;
        data_out_0_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(data_in_0_ready), 1);
        tick();
        data_in_0_valid = 1'b0;
        check(tag, data_out_0, exp);
        check({tag, "_valid"}, 32'(data_out_0_valid), 1);
        tick();
        check({tag, "_drained"}, 32'(data_out_0_valid), 0);
    endtask

    logic [7:0] t2_in  [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    logic [7:0] t2_exp [4] = '{8'hFF, 8'h80, 8'h7F, 8'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        lut_wr_data      = '0;
        lut_wr_valid     = 1'b0;
        lut_reload       = 1'b0;
        data_in_0        = '0;
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        repeat (2) tick();
        check("rst_loaded", 32'(lut_loaded), 0);
        check("rst_wr_ready", 32'(lut_wr_ready), 1);
        check("rst_out_valid", 32'(data_out_0_valid), 0);
        check("rst_out_data", data_out_0, 0);
        check("rst_in_ready", 32'(data_in_0_ready), 0);
        rst = 1'b0;

        // Inverse table, entry[i] = 255-i
        load_table(0);

        // Back-to-back beats, no bubbles
        for (int k = 0; k < 4; k++) begin
            data_in_0       = {4{t2_in[k]}};
            data_in_0_valid = 1'b1;
            #1;
            check("b2b_in_ready", 32'(data_in_0_ready), 1);
            tick();
            check("b2b_out", data_out_0, {4{t2_exp[k]}});
            check("b2b_valid", 32'(data_out_0_valid), 1);
        end
        data_in_0_valid = 1'b0;
        tick();
        check("b2b_drained", 32'(data_out_0_valid), 0);

        // Backpressure: beat 0x10 stalls for three cycles while 0x20 waits
        data_out_0_ready = 1'b0;
        data_in_0        = {4{8'h10}};
        data_in_0_valid  = 1'b1;
        tick();
        check("bp_first", data_out_0, {4{8'hEF}});
        data_in_0 = {4{8'h20}};
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready_low", 32'(data_in_0_ready), 0);
            tick();
            check("bp_hold", data_out_0, {4{8'hEF}});
            check("bp_hold_valid", 32'(data_out_0_valid), 1);
        end
        data_out_0_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(data_in_0_ready), 1);
        tick();
        data_in_0_valid = 1'b0;
        check("bp_second", data_out_0, {4{8'hDF}});
        tick();
        check("bp_no_dup", 32'(data_out_0_valid), 0);

        // Reload in the same cycle as an input transfer
        data_in_0        = {4{8'h05}};
        data_in_0_valid  = 1'b1;
        lut_reload       = 1'b1;
        data_out_0_ready = 1'b0;
        #1;
        check("rl_in_ready", 32'(data_in_0_ready), 1);
        tick();
        lut_reload = 1'b0;
        check("rl_last_beat", data_out_0, {4{8'hFA}});
        check("rl_last_valid", 32'(data_out_0_valid), 1);
        check("rl_loaded_low", 32'(lut_loaded), 0);
        check("rl_in_blocked", 32'(data_in_0_ready), 0);
        tick();
        check("drain_wr_ready_low", 32'(lut_wr_ready), 0);
        check("drain_hold", data_out_0, {4{8'hFA}});
        data_out_0_ready = 1'b1;
        tick();
        check("drain_done", 32'(data_out_0_valid), 0);
        load_table(1);
        check("reloaded_in_ready", 32'(data_in_0_ready), 1);
        tick();
        data_in_0_valid = 1'b0;
        check("reloaded_lookup", data_out_0, {4{8'h05}});
        tick();
        check("reloaded_drained", 32'(data_out_0_valid), 0);

        // Reset in the middle of a load
        lut_reload = 1'b1;
        tick();
        lut_reload = 1'b0;
        tick();
        check("partial_wr_ready", 32'(lut_wr_ready), 1);
        for (int i = 0; i < 100; i++) begin
            lut_wr_data  = 8'h33;
            lut_wr_valid = 1'b1;
            tick();
        end
        lut_wr_valid = 1'b0;
        check("partial_not_loaded", 32'(lut_loaded), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_loaded", 32'(lut_loaded), 0);
        check("midrst_wr_ready", 32'(lut_wr_ready), 1);
        check("midrst_out_data", data_out_0, 0);
        load_table(2);
        lookup("newtbl", 32'h0064C87F, 32'hA5C16DDA);

        // Four independent lanes in one beat
        lookup("lanes", 32'h010280FF, 32'hA4A7255A);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
